// File: rtl/clint_mh_pkg.sv
// Register map and helpers for the multi-hart CLINT.
package clint_mh_pkg;

    localparam logic [15:0] MSIP_BASE         = 16'h0000;
    localparam int unsigned MSIP_STRIDE       = 4;
    localparam logic [15:0] MTIMECMP_BASE     = 16'h4000;
    localparam int unsigned MTIMECMP_STRIDE   = 8;
    localparam logic [15:0] MTIME_HI_SNAP_OFF = 16'hBFEC;
    localparam logic [15:0] CTRL_OFF          = 16'hBFF0;
    localparam logic [15:0] PRESCALE_OFF      = 16'hBFF4;
    localparam logic [15:0] MTIME_LO_OFF      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF      = 16'hBFFC;

    localparam int unsigned CTRL_COUNT_EN_BIT = 0;

    function automatic int unsigned hart_idx_w(input int unsigned num_harts);
        return (num_harts > 1) ? $clog2(num_harts) : 1;
    endfunction

    function automatic logic [31:0] mask_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/urv_cfg.sv
// Global configuration constants for the uRV core and its peripheral bus.
package urv_cfg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned CSR_TIME_W = 64;

endpackage

// File: rtl/urv_typedef.sv
// Shared request/response types for the uRV peripheral mem_if bus.
package urv_typedef;

    import urv_cfg::*;

    localparam logic [1:0] MEM_READ  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0]   req_addr;
        logic [MEM_DATA_W-1:0]   req_data;
        logic [MEM_DATA_W/8-1:0] req_mask;
        logic [1:0]              req_type;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] resp_data;
    } mem_resp_t;

endpackage

// File: rtl/clint_mh_timer.sv
// Shared mtime counter with prescaler, count enable and coherent high-word snapshot.
module clint_mh_timer
    import clint_mh_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_ctrl,
    input  logic                  wr_prescale,
    input  logic                  wr_mtime_lo,
    input  logic                  wr_mtime_hi,
    input  logic                  snap_capture,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wmask,
    output logic                  count_en,
    output logic [PRESCALE_W-1:0] prescale,
    output logic [63:0]           mtime,
    output logic [31:0]           mtime_hi_snap
);

    logic [PRESCALE_W-1:0] pre_cnt_q, prescale_q;
    logic                  count_en_q;
    logic [63:0]           mtime_q;
    logic [31:0]           snap_q;
    logic                  tick;
    logic [31:0]           prescale_merged;

    assign tick            = count_en_q && (pre_cnt_q == prescale_q);
    assign prescale_merged = mask_merge(32'(prescale_q), wdata, wmask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q  <= '0;
            prescale_q <= '0;
            count_en_q <= 1'b0;
            mtime_q    <= '0;
            snap_q     <= '0;
        end else begin
            if (wr_ctrl && wmask[0]) count_en_q <= wdata[CTRL_COUNT_EN_BIT];

            if (wr_prescale) begin
                prescale_q <= prescale_merged[PRESCALE_W-1:0];
                pre_cnt_q  <= '0;
            end else if (count_en_q) begin
                pre_cnt_q <= tick ? '0 : pre_cnt_q + 1'b1;
            end

            // A software write to either half suppresses that cycle's increment.
            if (wr_mtime_lo || wr_mtime_hi) begin
                if (wr_mtime_lo) mtime_q[31:0]  <= mask_merge(mtime_q[31:0], wdata, wmask);
                if (wr_mtime_hi) mtime_q[63:32] <= mask_merge(mtime_q[63:32], wdata, wmask);
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end

            if (snap_capture) snap_q <= mtime_q[63:32];
        end
    end

    assign count_en      = count_en_q;
    assign prescale      = prescale_q;
    assign mtime         = mtime_q;
    assign mtime_hi_snap = snap_q;

endmodule

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: per-hart msip/mtimecmp, shared mtime, mem_if slave.
module clint_mh
    import urv_cfg::*;
    import urv_typedef::*;
    import clint_mh_pkg::*;
#(
    parameter int unsigned NUM_HARTS    = 2,
    parameter int unsigned PRESCALE_W   = 16,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req_valid,
    output logic                  mem_req_ready,
    input  mem_req_t              mem_req,
    output logic                  mem_resp_valid,
    input  logic                  mem_resp_ready,
    output mem_resp_t             mem_resp,
    output logic [NUM_HARTS-1:0]  soft_irq,
    output logic [NUM_HARTS-1:0]  time_irq,
    output logic [CSR_TIME_W-1:0] time_val
);

    logic [13:0] word;
    logic        accept, wr, rd;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        resp_pending_q;
    logic [31:0] resp_data_q;
    logic [31:0] rdata;
    logic [31:0] hart_rdata [NUM_HARTS];
    logic        sel_snap, sel_ctrl, sel_prescale, sel_mtime_lo, sel_mtime_hi;
    logic                  count_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [63:0]           mtime;
    logic [31:0]           mtime_hi_snap;
    logic                  unused_addr;

    assign word        = mem_req.req_addr[15:2];
    assign unused_addr = ^{mem_req.req_addr[MEM_ADDR_W-1:16], mem_req.req_addr[1:0]};
    assign wdata       = mem_req.req_data;
    assign wmask       = mem_req.req_mask;
    assign accept      = mem_req_valid && !resp_pending_q;
    assign wr          = accept && (mem_req.req_type == MEM_WRITE);
    assign rd          = accept && (mem_req.req_type != MEM_WRITE);

    assign sel_snap     = (word == MTIME_HI_SNAP_OFF[15:2]);
    assign sel_ctrl     = (word == CTRL_OFF[15:2]);
    assign sel_prescale = (word == PRESCALE_OFF[15:2]);
    assign sel_mtime_lo = (word == MTIME_LO_OFF[15:2]);
    assign sel_mtime_hi = (word == MTIME_HI_OFF[15:2]);

    clint_mh_timer #(
        .PRESCALE_W (PRESCALE_W)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .wr_ctrl       (wr && sel_ctrl),
        .wr_prescale   (wr && sel_prescale),
        .wr_mtime_lo   (wr && sel_mtime_lo),
        .wr_mtime_hi   (wr && sel_mtime_hi),
        .snap_capture  (rd && sel_mtime_lo),
        .wdata         (wdata),
        .wmask         (wmask),
        .count_en      (count_en),
        .prescale      (prescale),
        .mtime         (mtime),
        .mtime_hi_snap (mtime_hi_snap)
    );

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        localparam logic [15:0] MsipAddr  = MSIP_BASE + 16'(MSIP_STRIDE * h);
        localparam logic [15:0] CmpLoAddr = MTIMECMP_BASE + 16'(MTIMECMP_STRIDE * h);
        localparam logic [15:0] CmpHiAddr = CmpLoAddr + 16'd4;

        logic        msip_q, time_irq_q;
        logic [63:0] mtimecmp_q;
        logic        sel_msip, sel_cmp_lo, sel_cmp_hi;

        assign sel_msip   = (word == MsipAddr[15:2]);
        assign sel_cmp_lo = (word == CmpLoAddr[15:2]);
        assign sel_cmp_hi = (word == CmpHiAddr[15:2]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                msip_q     <= 1'b0;
                mtimecmp_q <= MTIMECMP_RST;
                time_irq_q <= 1'b0;
            end else begin
                if (wr && sel_msip && wmask[0]) msip_q <= wdata[0];
                if (wr && sel_cmp_lo) mtimecmp_q[31:0]  <= mask_merge(mtimecmp_q[31:0], wdata, wmask);
                if (wr && sel_cmp_hi) mtimecmp_q[63:32] <= mask_merge(mtimecmp_q[63:32], wdata, wmask);
                time_irq_q <= (mtime >= mtimecmp_q);
            end
        end

        assign soft_irq[h]   = msip_q;
        assign time_irq[h]   = time_irq_q;
        assign hart_rdata[h] = sel_msip   ? 32'(msip_q)       :
                               sel_cmp_lo ? mtimecmp_q[31:0]  :
                               sel_cmp_hi ? mtimecmp_q[63:32] : 32'd0;
    end

    // Selects are mutually exclusive, so OR-combining the sources is a plain mux.
    always_comb begin
        rdata = '0;
        for (int h = 0; h < NUM_HARTS; h++) rdata |= hart_rdata[h];
        if (sel_snap)     rdata |= mtime_hi_snap;
        if (sel_ctrl)     rdata |= 32'(count_en);
        if (sel_prescale) rdata |= 32'(prescale);
        if (sel_mtime_lo) rdata |= mtime[31:0];
        if (sel_mtime_hi) rdata |= mtime[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_pending_q <= 1'b0;
            resp_data_q    <= '0;
        end else if (accept) begin
            resp_pending_q <= 1'b1;
            resp_data_q    <= wr ? 32'd0 : rdata;
        end else if (resp_pending_q && mem_resp_ready) begin
            resp_pending_q <= 1'b0;
        end
    end

    assign mem_req_ready      = !resp_pending_q;
    assign mem_resp_valid     = resp_pending_q;
    assign mem_resp.resp_data = resp_data_q;
    assign time_val           = mtime;

endmodule

// File: tb/tb_clint_mh.sv
// Directed, table-driven bench for clint_mh with hand-written timing sequences.
module tb_clint_mh;

    import urv_cfg::*;
    import urv_typedef::*;

    localparam logic [15:0] A_SNAP  = 16'hBFEC;
    localparam logic [15:0] A_CTRL  = 16'hBFF0;
    localparam logic [15:0] A_PRE   = 16'hBFF4;
    localparam logic [15:0] A_MTLO  = 16'hBFF8;
    localparam logic [15:0] A_MTHI  = 16'hBFFC;
    localparam logic [15:0] A_CMP1L = 16'h4008;
    localparam logic [15:0] A_CMP1H = 16'h400C;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  mem_req_valid = 1'b0;
    logic                  mem_req_ready;
    mem_req_t              mem_req = '0;
    logic                  mem_resp_valid;
    logic                  mem_resp_ready = 1'b1;
    mem_resp_t             mem_resp;
    logic [1:0]            soft_irq, time_irq;
    logic [CSR_TIME_W-1:0] time_val;

    clint_mh #(
        .NUM_HARTS    (2),
        .PRESCALE_W   (16),
        .MTIMECMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req        (mem_req),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp       (mem_resp),
        .soft_irq       (soft_irq),
        .time_irq       (time_irq),
        .time_val       (time_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] rdv;

    function automatic vec_t mk(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                                input logic [3:0] mask, input logic [31:0] exp, input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.mask = mask; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a request and returns 1ns after the edge that accepted it.
    task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                         input logic [3:0] mask);
        int n = 0;
        @(negedge clk);
        mem_req_valid     = 1'b1;
        mem_req.req_addr  = {16'h0000, addr};
        mem_req.req_data  = data;
        mem_req.req_mask  = mask;
        mem_req.req_type  = wr ? MEM_WRITE : MEM_READ;
        while (!mem_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req_ready) check("req_ready_timeout", {63'd0, mem_req_ready}, 64'd1);
        @(posedge clk);
        #1;
        mem_req_valid = 1'b0;
    endtask

    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, output logic [31:0] rd);
        int n = 0;
        issue(wr, addr, data, mask);
        if (!mem_resp_valid) check("resp_valid_missing", {63'd0, mem_resp_valid}, 64'd1);
        rd = mem_resp.resp_data;
        while (mem_resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (mem_resp_valid) check("resp_consume_timeout", {63'd0, mem_resp_valid}, 64'd0);
    endtask

    task automatic wr32(input logic [15:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        xfer(1'b1, addr, data, 4'hF, dummy);
    endtask

    initial begin
        // Reset and reset-state outputs.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req_ready", {63'd0, mem_req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, mem_resp_valid}, 64'd0);
        check("rst_resp_data", {32'd0, mem_resp.resp_data}, 64'd0);
        check("rst_soft_irq", {62'd0, soft_irq}, 64'd0);
        check("rst_time_irq", {62'd0, time_irq}, 64'd0);
        check("rst_time_val", time_val, 64'd0);

        // Register access table; counting is off so mtime only changes by writes.
        vecs.push_back(mk(1'b0, A_CMP1L, 32'h0, 4'hF, 32'hFFFF_FFFF, "cmp1_lo_rst"));
        vecs.push_back(mk(1'b0, A_CMP1H, 32'h0, 4'hF, 32'hFFFF_FFFF, "cmp1_hi_rst"));
        vecs.push_back(mk(1'b0, 16'h0000, 32'h0, 4'hF, 32'h0, "msip0_rst"));
        vecs.push_back(mk(1'b0, A_CTRL, 32'h0, 4'hF, 32'h0, "ctrl_rst"));
        vecs.push_back(mk(1'b0, A_PRE, 32'h0, 4'hF, 32'h0, "prescale_rst"));
        vecs.push_back(mk(1'b0, A_MTLO, 32'h0, 4'hF, 32'h0, "mtime_lo_rst"));
        vecs.push_back(mk(1'b1, A_CMP1L, 32'h1234_5678, 4'hF, 32'h0, "cmp1_lo_wr"));
        vecs.push_back(mk(1'b0, A_CMP1L, 32'h0, 4'hF, 32'h1234_5678, "cmp1_lo_rd"));
        vecs.push_back(mk(1'b1, A_CMP1L, 32'hAABB_CCDD, 4'b0101, 32'h0, "cmp1_lo_wr_mask"));
        vecs.push_back(mk(1'b0, A_CMP1L, 32'h0, 4'hF, 32'h12BB_56DD, "cmp1_lo_rd_mask"));
        vecs.push_back(mk(1'b1, 16'h0000, 32'h1, 4'b0000, 32'h0, "msip0_wr_nomask"));
        vecs.push_back(mk(1'b0, 16'h0000, 32'h0, 4'hF, 32'h0, "msip0_rd_nomask"));
        vecs.push_back(mk(1'b1, 16'h0014, 32'h1, 4'hF, 32'h0, "msip5_wr"));
        vecs.push_back(mk(1'b0, 16'h0014, 32'h0, 4'hF, 32'h0, "msip5_rd"));
        vecs.push_back(mk(1'b0, 16'h0004, 32'h0, 4'hF, 32'h0, "msip1_rd"));
        vecs.push_back(mk(1'b0, 16'h4028, 32'h0, 4'hF, 32'h0, "cmp5_lo_rd"));
        vecs.push_back(mk(1'b0, 16'h1234, 32'h0, 4'hF, 32'h0, "unmapped_rd"));
        vecs.push_back(mk(1'b1, A_PRE, 32'hFFFF_0123, 4'hF, 32'h0, "prescale_wr"));
        vecs.push_back(mk(1'b0, A_PRE, 32'h0, 4'hF, 32'h0000_0123, "prescale_rd"));
        vecs.push_back(mk(1'b1, A_PRE, 32'h0, 4'hF, 32'h0, "prescale_clr"));
        vecs.push_back(mk(1'b1, A_MTLO, 32'hDEAD_BEEF, 4'hF, 32'h0, "mtime_lo_wr"));
        vecs.push_back(mk(1'b0, A_MTLO, 32'h0, 4'hF, 32'hDEAD_BEEF, "mtime_lo_rd"));
        vecs.push_back(mk(1'b1, A_MTHI, 32'h7, 4'hF, 32'h0, "mtime_hi_wr"));
        vecs.push_back(mk(1'b0, A_MTHI, 32'h0, 4'hF, 32'h7, "mtime_hi_rd"));
        vecs.push_back(mk(1'b0, A_MTLO, 32'h0, 4'hF, 32'hDEAD_BEEF, "mtime_lo_snap"));
        vecs.push_back(mk(1'b1, A_MTHI, 32'h0, 4'hF, 32'h0, "mtime_hi_clr"));
        vecs.push_back(mk(1'b0, A_SNAP, 32'h0, 4'hF, 32'h7, "snap_rd"));
        vecs.push_back(mk(1'b1, A_SNAP, 32'h55, 4'hF, 32'h0, "snap_wr_ro"));
        vecs.push_back(mk(1'b0, A_SNAP, 32'h0, 4'hF, 32'h7, "snap_rd_ro"));
        vecs.push_back(mk(1'b0, A_MTHI, 32'h0, 4'hF, 32'h0, "mtime_hi_rd0"));
        vecs.push_back(mk(1'b1, A_MTLO, 32'h0, 4'hF, 32'h0, "mtime_lo_clr"));

        foreach (vecs[i]) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask, rdv);
            check(vecs[i].name, {32'd0, rdv}, {32'd0, vecs[i].exp});
        end

        // MSIP drives soft_irq the cycle after the write.
        check("soft_irq_pre", {62'd0, soft_irq}, 64'd0);
        issue(1'b1, 16'h0000, 32'h1, 4'b0001);
        check("soft_irq_set", {62'd0, soft_irq}, 64'd1);
        @(posedge clk);
        #1;
        wr32(16'h0000, 32'h0);
        check("soft_irq_clr", {62'd0, soft_irq}, 64'd0);

        // Count enable with PRESCALE=0: 0,1,2 on consecutive cycles.
        issue(1'b1, A_CTRL, 32'h1, 4'hF);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            check("count_p0", time_val, 64'(k));
        end
        wr32(A_CTRL, 32'h0);

        // PRESCALE=3: one increment every four cycles, then PRESCALE=0 mid-count.
        wr32(A_PRE, 32'h3);
        wr32(A_MTLO, 32'h0);
        wr32(A_MTHI, 32'h0);
        issue(1'b1, A_CTRL, 32'h1, 4'hF);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            check("count_p3", time_val, 64'(k / 4));
        end
        issue(1'b1, A_PRE, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            check("count_p3_to_p0", time_val, 64'(2 + k));
        end
        wr32(A_CTRL, 32'h0);

        // Carry into the high word, full wrap, and write-beats-tick.
        wr32(A_MTLO, 32'hFFFF_FFFF);
        wr32(A_MTHI, 32'h0);
        issue(1'b1, A_CTRL, 32'h1, 4'hF);
        check("carry_pre", time_val, 64'h0000_0000_FFFF_FFFF);
        @(posedge clk); #1;
        check("carry_post", time_val, 64'h0000_0001_0000_0000);
        wr32(A_CTRL, 32'h0);
        wr32(A_MTLO, 32'hFFFF_FFFF);
        wr32(A_MTHI, 32'hFFFF_FFFF);
        issue(1'b1, A_CTRL, 32'h1, 4'hF);
        check("wrap_pre", time_val, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        check("wrap_post", time_val, 64'h0);
        issue(1'b1, A_MTLO, 32'h100, 4'hF);
        check("wr_beats_tick", time_val, 64'h100);
        @(posedge clk); #1;
        check("wr_then_tick", time_val, 64'h101);
        wr32(A_CTRL, 32'h0);

        // Timer interrupt one cycle after mtime reaches mtimecmp[1].
        wr32(A_MTLO, 32'h1E);
        wr32(A_MTHI, 32'h0);
        wr32(A_CMP1L, 32'h20);
        wr32(A_CMP1H, 32'h0);
        @(posedge clk); #1;
        check("tirq_idle", {62'd0, time_irq}, 64'd0);
        issue(1'b1, A_CTRL, 32'h1, 4'hF);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            check("tirq_mtime", time_val, 64'(32'h1E + k));
            check("tirq_low", {62'd0, time_irq}, 64'd0);
        end
        @(posedge clk); #1;
        check("tirq_set", {62'd0, time_irq}, 64'd2);
        issue(1'b1, A_CMP1L, 32'h100, 4'hF);
        check("tirq_hold_on_wr", {62'd0, time_irq}, 64'd2);
        @(posedge clk); #1;
        check("tirq_clr", {62'd0, time_irq}, 64'd0);
        wr32(A_CTRL, 32'h0);

        // Back-pressure: response held stable, no new request accepted.
        mem_resp_ready = 1'b0;
        issue(1'b0, A_CMP1L, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {63'd0, mem_resp_valid}, 64'd1);
            check("bp_data", {32'd0, mem_resp.resp_data}, 64'h100);
            check("bp_req_ready", {63'd0, mem_req_ready}, 64'd0);
            if (i == 0) begin
                mem_req_valid    = 1'b1;
                mem_req.req_addr = 32'h0;
                mem_req.req_data = 32'h1;
                mem_req.req_mask = 4'hF;
                mem_req.req_type = MEM_WRITE;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_consumed", {63'd0, mem_resp_valid}, 64'd0);
        check("bp_ready_back", {63'd0, mem_req_ready}, 64'd1);
        check("bp_no_msip", {62'd0, soft_irq}, 64'd0);

        // Reset mid-transaction drops the pending response.
        mem_resp_ready = 1'b0;
        issue(1'b0, A_CMP1L, 32'h0, 4'hF);
        check("mid_rst_pending", {63'd0, mem_resp_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, mem_resp_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, mem_req_ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_resp", {63'd0, mem_resp_valid}, 64'd0);
        end
        xfer(1'b0, A_CMP1L, 32'h0, 4'hF, rdv);
        check("post_rst_cmp1", {32'd0, rdv}, 64'hFFFF_FFFF);
        check("post_rst_mtime", time_val, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
